// File: rtl/comp_pkg.sv
// Shared definitions for comparator BIST: FSM state encoding and the golden
// comparator response, also usable by comparator testbenches.
package comp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Expected {gt, lt, eq} for unsigned operands (callers zero-extend to 32 bits).
  function automatic logic [2:0] comp_expected(input logic [31:0] op_a,
                                               input logic [31:0] op_b);
    return {op_a > op_b, op_a < op_b, op_a == op_b};
  endfunction

endpackage

// File: rtl/comp_vec_gen.sv
// Nested a/b vector counter: b is the inner loop, a the outer loop.
module comp_vec_gen #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             last
);

  localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] cnt;

  // Concatenating {a, b} into one counter makes b wrap into an a increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= cnt + ONE;
    end
  end

  assign a    = cnt[2*WIDTH-1:WIDTH];
  assign b    = cnt[WIDTH-1:0];
  assign last = &cnt;

endmodule

// File: rtl/comp_bist_checker.sv
// BIST sweep for a magnitude comparator: drives every a/b pair, waits SETTLE
// cycles, checks {gt,lt,eq} and records the error count and first failure.
module comp_bist_checker
  import comp_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*WIDTH:0] err_cnt,
  output logic             first_err_vld,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output state_t           state_dbg
);

  // Handshake: start is a level request accepted on any rising edge while in
  // IDLE or DONE and ignored otherwise; busy is high for the whole sweep, done
  // rises with the final result and stays until the next accepted start.

  localparam logic [2*WIDTH:0] ERR_MAX    = {1'b1, {(2*WIDTH){1'b0}}};
  localparam logic [3:0]       SETTLE_END = 4'(SETTLE - 1);

  state_t           state;
  logic [3:0]       settle_cnt;
  logic             vec_clear;
  logic             vec_adv;
  logic             vec_last;
  logic             mismatch;
  logic [2*WIDTH:0] err_inc;

  assign vec_clear = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign vec_adv   = (state == ST_SAMPLE) && !vec_last;
  assign mismatch  = ({gt, lt, eq} != comp_expected(32'(a), 32'(b)));
  assign err_inc   = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + 1'b1;

  comp_vec_gen #(.WIDTH(WIDTH)) u_vec_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (vec_clear),
    .advance (vec_adv),
    .a       (a),
    .b       (b),
    .last    (vec_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      settle_cnt    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_a   <= '0;
      first_err_b   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_DRIVE;
            settle_cnt    <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_a   <= '0;
            first_err_b   <= '0;
          end
        end
        ST_DRIVE: begin
          if (settle_cnt == SETTLE_END) begin
            state      <= ST_SAMPLE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            err_cnt <= err_inc;
            if (!first_err_vld) begin
              first_err_vld <= 1'b1;
              first_err_a   <= a;
              first_err_b   <= b;
            end
          end
          if (vec_last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (err_cnt == '0);
          end else begin
            state <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_comp_bist_checker.sv
// Bench for comp_bist_checker (WIDTH=2, SETTLE=1) with a behavioural
// comparator that can be made faulty, and a sweep-level reference model.
module tb_comp_bist_checker;
  import comp_pkg::*;

  localparam int WIDTH  = 2;
  localparam int SETTLE = 1;
  localparam int NVEC   = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             gt;
  logic             lt;
  logic             eq;
  logic             busy;
  logic             done;
  logic             pass;
  logic [2*WIDTH:0] err_cnt;
  logic             first_err_vld;
  logic [WIDTH-1:0] first_err_a;
  logic [WIDTH-1:0] first_err_b;
  state_t           state_dbg;

  int checks   = 0;
  int failures = 0;

  int         fault_mode = 0;
  logic [2:0] rand_tab [NVEC];
  logic [3:0] exp_q [$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  comp_bist_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .a             (a),
    .b             (b),
    .gt            (gt),
    .lt            (lt),
    .eq            (eq),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_err_vld (first_err_vld),
    .first_err_a   (first_err_a),
    .first_err_b   (first_err_b),
    .state_dbg     (state_dbg)
  );

  // Comparator under test: 0 good, 1 gt stuck 0, 2 gt/lt swapped,
  // 3 gt forced high on eq, 4 random table, 5 all outputs stuck 0.
  function automatic logic [2:0] resp_for(input int mode, input int va, input int vb);
    logic g, l, e;
    g = (va > vb);
    l = (va < vb);
    e = (va == vb);
    case (mode)
      1:       return {1'b0, l, e};
      2:       return {l, g, e};
      3:       return {g | e, l, e};
      4:       return rand_tab[va*4 + vb];
      5:       return 3'b000;
      default: return {g, l, e};
    endcase
  endfunction

  always_comb {gt, lt, eq} = resp_for(fault_mode, int'(a), int'(b));

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_sweep(input int mode, input bit pulse_mid);
    int e_err, e_fa, e_fb, cycles, pulse_at;
    bit e_fv;
    logic [3:0] vec;
    fault_mode = mode;
    e_err = 0; e_fv = 0; e_fa = 0; e_fb = 0;
    exp_q.delete();
    for (int va = 0; va < 4; va++) begin
      for (int vb = 0; vb < 4; vb++) begin
        exp_q.push_back(4'(va*4 + vb));
        if (resp_for(mode, va, vb) != {va > vb, va < vb, va == vb}) begin
          if (e_err < NVEC) e_err++;
          if (!e_fv) begin
            e_fv = 1; e_fa = va; e_fb = vb;
          end
        end
      end
    end
    pulse_at = pulse_mid ? int'($urandom_range(1, 30)) : -1;

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done_clr", 32'(done), 32'd0);
    check("start_err_clr", 32'(err_cnt), 32'd0);
    check("start_fev_clr", 32'(first_err_vld), 32'd0);
    cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      if (state_dbg == ST_SAMPLE) begin
        if (exp_q.size() == 0) begin
          check("vec_extra", 32'd1, 32'd0);
        end else begin
          vec = exp_q.pop_front();
          check("vec_order", 32'({a, b}), 32'(vec));
        end
      end
      start = (cycles == pulse_at);
    end
    start = 1'b0;
    check("latency", 32'(cycles), 32'(NVEC * (SETTLE + 1)));
    check("done", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("pass", 32'(pass), 32'(e_err == 0));
    check("err_cnt", 32'(err_cnt), 32'(e_err));
    check("first_err_vld", 32'(first_err_vld), 32'(e_fv));
    if (e_fv) begin
      check("first_err_a", 32'(first_err_a), 32'(e_fa));
      check("first_err_b", 32'(first_err_b), 32'(e_fb));
    end
    check("hold_a", 32'(a), 32'd3);
    check("hold_b", 32'(b), 32'd3);
    check("vec_count", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("done_stable", 32'(done), 32'd1);
    check("err_stable", 32'(err_cnt), 32'(e_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, 32'(a), 32'd0);
    check({tag, "_b"}, 32'(b), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err"}, 32'(err_cnt), 32'd0);
    check({tag, "_fev"}, 32'(first_err_vld), 32'd0);
    check({tag, "_fea"}, 32'(first_err_a), 32'd0);
    check({tag, "_feb"}, 32'(first_err_b), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int wait_cyc;
    bit saw_done;
    rst_n = 1'b0;
    start = 1'b1;
    for (int i = 0; i < NVEC; i++) rand_tab[i] = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_start", 32'(state_dbg), 32'(ST_IDLE));

    run_sweep(0, 0);
    run_sweep(1, 0);
    run_sweep(0, 0);
    run_sweep(2, 0);
    run_sweep(3, 0);
    run_sweep(5, 0);
    run_sweep(0, 1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NVEC; i++) begin
        if ($urandom_range(0, 1) == 1) rand_tab[i] = 3'($urandom_range(0, 7));
        else rand_tab[i] = {(i / 4) > (i % 4), (i / 4) < (i % 4), (i / 4) == (i % 4)};
      end
      run_sweep(4, 1);
    end

    // Reset in the middle of a sweep, at vector a=1, b=1.
    fault_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_cyc = 0;
    while (!(a == 2'd1 && b == 2'd1) && wait_cyc < 100) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    check("reach_vec_1_1", 32'(wait_cyc < 100), 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    check_all_zero("mid_reset");
    saw_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1;
    end
    check("no_done_after_reset", 32'(saw_done), 32'd0);
    run_sweep(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comp_bist_checker.md
COMP_BIST_CHECKER -- requirements
Module: comp_bist_checker

Interface
REQ-001 Parameter WIDTH, default 2, SHALL set the operand width of the comparator under test.
REQ-002 Parameter SETTLE, default 1, range 1-15, SHALL set the number of wait cycles between driving a vector and sampling the result.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset; it SHALL be synchronous and active-low.
REQ-005 start  input  1  begins a sweep; it SHALL be sampled only in IDLE or DONE.
REQ-006 a  output  WIDTH  operand A driven to the comparator.
REQ-007 b  output  WIDTH  operand B driven to the comparator.
REQ-008 gt, lt, eq  input  1 each  comparator responses.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high from sweep completion until the next start or reset.
REQ-011 pass  output  1  equals done AND (err_cnt == 0).
REQ-012 err_cnt  output  2*WIDTH+1  number of mismatching vectors.
REQ-013 first_err_vld, first_err_a[WIDTH], first_err_b[WIDTH]  output  first failing vector.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, DRIVE, SAMPLE and DONE.
REQ-015 Transition IDLE/DONE -> DRIVE on start=1: a=0, b=0, err_cnt=0, first_err_vld=0, done=0, busy=1.
REQ-016 DRIVE SHALL hold a and b stable for SETTLE cycles, then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle and compare {gt,lt,eq} against the expected values gt=(a>b), lt=(a<b), eq=(a==b), unsigned.
REQ-018 A mismatch in any bit SHALL count as one error, including non-one-hot responses such as all-zero or multiple bits set.
REQ-019 On a mismatch, err_cnt SHALL increment and saturate at 2^(2*WIDTH).
REQ-020 On the first mismatch only, the block SHALL latch first_err_a and first_err_b and set first_err_vld.
REQ-021 Vector order SHALL be b as the inner loop (0..2^WIDTH-1) and a as the outer loop.
REQ-022 After SAMPLE, b SHALL wrap to 0 with a incrementing; the FSM SHALL then return to DRIVE.
REQ-023 After SAMPLE of a=b=all-ones, the FSM SHALL go to DONE with busy=0 and done=1; a and b SHALL hold their last values.
REQ-024 Sweep latency SHALL be 2^(2*WIDTH)*(SETTLE+1) cycles from the start-sampling edge to the done=1 edge.
REQ-025 start SHALL be ignored in DRIVE and SAMPLE.
REQ-026 start in DONE SHALL restart the sweep per REQ-015.
REQ-027 err_cnt and the first_err outputs SHALL stay stable in DONE until restart.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE and clear a, b, busy, done, pass, err_cnt, first_err_vld, first_err_a and first_err_b to 0.
REQ-029 Reset SHALL take effect mid-sweep, abandoning the sweep with no done pulse.
REQ-030 rst_n SHALL take priority over start on the same edge.

Structure
REQ-031 The FSM state encoding and the expected-result function SHALL live in a shared package, comp_pkg.
REQ-032 The expected-result function SHALL be reusable by the comparator testbenches.
REQ-033 One sub-module, comp_vec_gen, SHALL be used: the a/b nested counter with advance and last outputs.
REQ-034 The design SHALL use no other hierarchy.

Verification (WIDTH=2, SETTLE=1)
REQ-035 Correct comparator attached, pulse start -> done after 32 cycles, pass=1, err_cnt=0, first_err_vld=0.
REQ-036 gt stuck at 0 -> err_cnt=6, first_err_a=1, first_err_b=0.
REQ-037 gt and lt swapped -> err_cnt=12, first_err_a=0, first_err_b=1.
REQ-038 gt forced to 1 whenever eq=1 -> err_cnt=4, first_err_a=0, first_err_b=0, pass=0.
REQ-039 start re-pulsed mid-sweep -> no effect, done still at cycle 32; start in DONE -> counters cleared and full sweep repeats.
REQ-040 rst_n=0 for one cycle at vector a=1,b=1 -> all outputs 0, state IDLE; subsequent start completes with pass=1.
